// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: pipeline request, MDU result, regfile write
// port and exit report, shared by the arbiter and its environment.
interface wb_port_arbiter_if;
    logic        pipe_valid_i;
    logic        pipe_wen_i;
    logic [4:0]  pipe_rd_i;
    logic [63:0] pipe_wdata_i;
    logic        pipe_exit_i;
    logic [63:0] pipe_pc_i;
    logic [63:0] pipe_a0_i;
    logic        pipe_ready_o;

    logic        mdu_valid_i;
    logic [4:0]  mdu_rd_i;
    logic [63:0] mdu_wdata_i;
    logic        mdu_busy_i;
    logic        mdu_ready_o;

    logic        rf_wen_o;
    logic [4:0]  rf_rd_o;
    logic [63:0] rf_wdata_o;

    logic        exit_o;
    logic        exit_good_o;
    logic [63:0] exit_pc_o;
    logic [63:0] exit_code_o;

    modport slave (
        input  pipe_valid_i, pipe_wen_i, pipe_rd_i, pipe_wdata_i,
        input  pipe_exit_i, pipe_pc_i, pipe_a0_i,
        input  mdu_valid_i, mdu_rd_i, mdu_wdata_i, mdu_busy_i,
        output pipe_ready_o, mdu_ready_o,
        output rf_wen_o, rf_rd_o, rf_wdata_o,
        output exit_o, exit_good_o, exit_pc_o, exit_code_o
    );

    modport master (
        output pipe_valid_i, pipe_wen_i, pipe_rd_i, pipe_wdata_i,
        output pipe_exit_i, pipe_pc_i, pipe_a0_i,
        output mdu_valid_i, mdu_rd_i, mdu_wdata_i, mdu_busy_i,
        input  pipe_ready_o, mdu_ready_o,
        input  rf_wen_o, rf_rd_o, rf_wdata_o,
        input  exit_o, exit_good_o, exit_pc_o, exit_code_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter between the in-order pipe and the MDU,
// with starvation guard and exit drain sequencing.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        EXIT  = 2'd2,
        HALT  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             rf_wen_q, rf_wen_d;
    logic [4:0]       rf_rd_q, rf_rd_d;
    logic [63:0]      rf_wdata_q, rf_wdata_d;
    logic             exit_q, exit_d;
    logic             exit_good_q, exit_good_d;
    logic [63:0]      exit_pc_q, exit_pc_d;
    logic [63:0]      exit_code_q, exit_code_d;

    logic pipe_need, mdu_need, starved;
    logic pipe_gnt, mdu_gnt;

    assign pipe_need = bus.pipe_valid_i & bus.pipe_wen_i;
    assign mdu_need  = bus.mdu_valid_i;
    assign starved   = (starve_q == LIMIT);

    // Grant decision; a wen=0 pipe op never competes for the port.
    always_comb begin
        pipe_gnt = 1'b0;
        mdu_gnt  = 1'b0;
        unique case (state_q)
            RUN: begin
                pipe_gnt = bus.pipe_valid_i &
                           (~bus.pipe_wen_i | ~mdu_need | starved);
                mdu_gnt  = mdu_need & ~(pipe_gnt & bus.pipe_wen_i);
            end
            DRAIN: mdu_gnt = mdu_need;
            EXIT:  ;
            HALT:  ;
        endcase
        if (rst) begin
            pipe_gnt = 1'b0;
            mdu_gnt  = 1'b0;
        end
    end

    assign bus.pipe_ready_o = pipe_gnt;
    assign bus.mdu_ready_o  = mdu_gnt;

    // Next-state: write issue, starvation count and exit sequencing.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        rf_wen_d    = 1'b0;
        rf_rd_d     = rf_rd_q;
        rf_wdata_d  = rf_wdata_q;
        exit_d      = 1'b0;
        exit_good_d = 1'b0;
        exit_pc_d   = exit_pc_q;
        exit_code_d = exit_code_q;

        if (pipe_gnt & bus.pipe_wen_i) begin
            rf_wen_d   = (bus.pipe_rd_i != 5'd0);
            rf_rd_d    = bus.pipe_rd_i;
            rf_wdata_d = bus.pipe_wdata_i;
        end else if (mdu_gnt) begin
            rf_wen_d   = (bus.mdu_rd_i != 5'd0);
            rf_rd_d    = bus.mdu_rd_i;
            rf_wdata_d = bus.mdu_wdata_i;
        end

        if (pipe_gnt) begin
            starve_d = '0;
        end else if (state_q == RUN && pipe_need && mdu_need
                     && !starved) begin
            starve_d = starve_q + CNT_W'(1);
        end

        unique case (state_q)
            RUN: begin
                if (pipe_gnt && bus.pipe_exit_i) begin
                    exit_pc_d   = bus.pipe_pc_i;
                    exit_code_d = bus.pipe_a0_i;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.mdu_busy_i && !bus.mdu_valid_i) begin
                    state_d     = EXIT;
                    exit_d      = 1'b1;
                    exit_good_d = (exit_code_q == 64'd0);
                end
            end
            EXIT: state_d = HALT;
            HALT: state_d = HALT;
        endcase
    end

    // State and registered outputs; synchronous reset drops everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            starve_q    <= '0;
            rf_wen_q    <= 1'b0;
            rf_rd_q     <= 5'd0;
            rf_wdata_q  <= 64'd0;
            exit_q      <= 1'b0;
            exit_good_q <= 1'b0;
            exit_pc_q   <= 64'd0;
            exit_code_q <= 64'd0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            rf_wen_q    <= rf_wen_d;
            rf_rd_q     <= rf_rd_d;
            rf_wdata_q  <= rf_wdata_d;
            exit_q      <= exit_d;
            exit_good_q <= exit_good_d;
            exit_pc_q   <= exit_pc_d;
            exit_code_q <= exit_code_d;
        end
    end

    assign bus.rf_wen_o    = rf_wen_q;
    assign bus.rf_rd_o     = rf_rd_q;
    assign bus.rf_wdata_o  = rf_wdata_q;
    assign bus.exit_o      = exit_q;
    assign bus.exit_good_o = exit_good_q;
    assign bus.exit_pc_o   = exit_pc_q;
    assign bus.exit_code_o = exit_code_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: vector table, hand-written corner
// sequences and random traffic against a behavioural model.
module tb_wb_port_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int exit_seen = 0;

    // model: phase 0 run, 1 drain, 2 exit pulse, 3 halted
    int          m_phase;
    int          m_lose;
    bit          e_wen;
    logic [4:0]  e_rd;
    logic [63:0] e_data;
    bit          e_exit, e_good;
    logic [63:0] e_pc, e_code;
    bit          s_pr, s_mr;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_lose = 0;
        e_wen = 0; e_rd = 0; e_data = 0;
        e_exit = 0; e_good = 0; e_pc = 0; e_code = 0;
    endtask

    // One clock: check readies before the edge, outputs just after.
    task automatic tick();
        bit epr, emr, pw, mv;
        @(negedge clk);
        pw  = bus.pipe_wen_i;
        mv  = bus.mdu_valid_i;
        epr = !rst && m_phase == 0 && bus.pipe_valid_i &&
              (!pw || !mv || m_lose >= LIMIT);
        emr = !rst && m_phase <= 1 && mv && !(epr && pw);
        s_pr = bus.pipe_ready_o;
        s_mr = bus.mdu_ready_o;
        chk("pipe_ready", s_pr, epr);
        chk("mdu_ready", s_mr, emr);
        if (rst) begin
            model_reset();
        end else begin
            e_exit = 0; e_good = 0; e_wen = 0;
            if (epr && pw) begin
                e_wen = bus.pipe_rd_i != 0;
                e_rd = bus.pipe_rd_i; e_data = bus.pipe_wdata_i;
            end else if (emr) begin
                e_wen = bus.mdu_rd_i != 0;
                e_rd = bus.mdu_rd_i; e_data = bus.mdu_wdata_i;
            end
            if (epr) m_lose = 0;
            else if (m_phase == 0 && bus.pipe_valid_i && pw && mv)
                m_lose = (m_lose + 1 > LIMIT) ? LIMIT : m_lose + 1;
            case (m_phase)
                0: if (epr && bus.pipe_exit_i) begin
                    e_pc = bus.pipe_pc_i; e_code = bus.pipe_a0_i;
                    m_phase = 1;
                end
                1: if (!bus.mdu_busy_i && !mv) begin
                    m_phase = 2; e_exit = 1; e_good = (e_code == 0);
                end
                default: m_phase = 3;
            endcase
        end
        @(posedge clk);
        #1;
        if (bus.exit_o) exit_seen++;
        chk("rf_wen", bus.rf_wen_o, e_wen);
        if (e_wen) begin
            chk("rf_rd", bus.rf_rd_o, e_rd);
            chk("rf_wdata", bus.rf_wdata_o, e_data);
        end
        chk("exit_o", bus.exit_o, e_exit);
        if (e_exit) chk("exit_good", bus.exit_good_o, e_good);
        chk("exit_pc", bus.exit_pc_o, e_pc);
        chk("exit_code", bus.exit_code_o, e_code);
    endtask

    task automatic drive(input bit pv, input bit pw, input logic [4:0] rd,
                         input logic [63:0] d, input bit mv,
                         input logic [4:0] mrd, input logic [63:0] md);
        bus.pipe_valid_i = pv; bus.pipe_wen_i = pw;
        bus.pipe_rd_i = rd; bus.pipe_wdata_i = d;
        bus.mdu_valid_i = mv; bus.mdu_rd_i = mrd; bus.mdu_wdata_i = md;
    endtask

    task automatic set_exit(input bit ex, input logic [63:0] pc,
                            input logic [63:0] a0, input bit busy);
        bus.pipe_exit_i = ex; bus.pipe_pc_i = pc;
        bus.pipe_a0_i = a0; bus.mdu_busy_i = busy;
    endtask

    typedef struct {
        bit pv; bit pw; logic [4:0] rd; logic [63:0] d;
        bit mv; logic [4:0] mrd; logic [63:0] md;
        bit x_pr; bit x_mr; bit x_wen; logic [4:0] x_rd; logic [63:0] x_d;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{1,1,5,64'h11,0,0,0,   1,0,1,5,64'h11};
        tbl[1] = '{1,1,6,64'h22,0,0,0,   1,0,1,6,64'h22};
        tbl[2] = '{1,1,3,64'h33,1,7,64'h77, 0,1,1,7,64'h77};
        tbl[3] = '{1,1,3,64'h33,0,0,0,   1,0,1,3,64'h33};
        tbl[4] = '{1,1,0,64'h44,0,0,0,   1,0,0,0,0};
        tbl[5] = '{1,0,9,64'h99,1,8,64'h88, 1,1,1,8,64'h88};
        tbl[6] = '{0,0,0,0,0,0,0,        0,0,0,0,0};

        model_reset();
        drive(0,0,0,0,0,0,0);
        set_exit(0,0,0,0);
        rst = 1;
        tick();
        chk("reset_rf_wen", bus.rf_wen_o, 0);
        chk("reset_exit", bus.exit_o, 0);
        #1 rst = 0;

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].pv, tbl[i].pw, tbl[i].rd, tbl[i].d,
                  tbl[i].mv, tbl[i].mrd, tbl[i].md);
            tick();
            chk($sformatf("vec%0d_pr", i), s_pr, tbl[i].x_pr);
            chk($sformatf("vec%0d_mr", i), s_mr, tbl[i].x_mr);
            chk($sformatf("vec%0d_wen", i), bus.rf_wen_o, tbl[i].x_wen);
            if (tbl[i].x_wen) begin
                chk($sformatf("vec%0d_rd", i), bus.rf_rd_o, tbl[i].x_rd);
                chk($sformatf("vec%0d_d", i), bus.rf_wdata_o, tbl[i].x_d);
            end
        end

        // starvation: four losses, then a forced pipe grant
        drive(1,1,3,64'h3a,1,7,64'h7a);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("starve%0d_pr", i), s_pr, i == 4);
            chk($sformatf("starve%0d_mr", i), s_mr, i != 4);
        end
        drive(0,0,0,0,0,0,0);
        tick();

        // exit with MDU busy 3 cycles, then its result lands
        exit_seen = 0;
        drive(1,0,0,0,0,0,0);
        set_exit(1, 64'h80000010, 0, 1);
        tick();
        drive(0,0,0,0,0,0,0);
        set_exit(0, 0, 0, 1);
        tick();
        tick();
        bus.mdu_busy_i = 0;
        drive(0,0,0,0,1,10,64'hd00d);
        tick();
        chk("drain_mdu_wr", bus.rf_wdata_o, 64'hd00d);
        drive(0,0,0,0,0,0,0);
        for (int i = 0; i < 8; i++) tick();
        chk("exit_pulses", exit_seen, 1);
        chk("exit_pc_hold", bus.exit_pc_o, 64'h80000010);

        // a0=1, MDU idle: DRAIN lasts one cycle
        rst = 1; tick(); #1 rst = 0;
        drive(1,0,0,0,0,0,0);
        set_exit(1, 64'h80000020, 1, 0);
        tick();
        drive(0,0,0,0,0,0,0);
        set_exit(0, 0, 0, 0);
        tick();
        chk("bad_exit_o", bus.exit_o, 1);
        chk("bad_exit_good", bus.exit_good_o, 0);
        drive(1,1,4,64'h5,0,0,0);
        tick();
        chk("halt_pr", s_pr, 0);

        // reset while draining, then a fresh write
        rst = 1; tick(); #1 rst = 0;
        drive(1,1,2,64'h2,0,0,0);
        set_exit(1, 64'h44, 0, 1);
        tick();
        drive(0,0,0,0,0,0,0);
        set_exit(0, 0, 0, 1);
        rst = 1; tick(); #1 rst = 0;
        chk("rst_drain_wen", bus.rf_wen_o, 0);
        chk("rst_drain_pc", bus.exit_pc_o, 0);
        bus.mdu_busy_i = 0;
        drive(1,1,12,64'hc,0,0,0);
        tick();
        chk("post_rst_pr", s_pr, 1);
        chk("post_rst_rd", bus.rf_rd_o, 12);

        // random traffic; MDU result held until accepted
        drive(0,0,0,0,0,0,0);
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            bus.pipe_valid_i = $urandom_range(0, 1);
            bus.pipe_wen_i   = $urandom_range(0, 3) != 0;
            bus.pipe_rd_i    = 5'($urandom_range(0, 31));
            bus.pipe_wdata_i = {$urandom, $urandom};
            bus.pipe_exit_i  = ($urandom_range(0, 19) == 0);
            bus.pipe_pc_i    = {$urandom, $urandom};
            bus.pipe_a0_i    = 64'($urandom_range(0, 1));
            bus.mdu_busy_i   = $urandom_range(0, 1);
            if (!bus.mdu_valid_i || s_mr) begin
                bus.mdu_valid_i = $urandom_range(0, 1);
                bus.mdu_rd_i    = 5'($urandom_range(0, 31));
                bus.mdu_wdata_i = {$urandom, $urandom};
            end
            tick();
            #1;
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
